// File: rtl/rom_fetch_arbiter_if.sv
// Request/grant/data bundle between the two ROM clients, the shared ROM and
// the fetch arbiter. The arbiter uses the slave view; clients and ROM use master.
interface rom_fetch_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4,
    parameter int BURST  = 4
);
    logic                    req0;
    logic [ADDR_W-1:0]       base0;
    logic                    req1;
    logic [ADDR_W-1:0]       base1;
    logic                    gnt0;
    logic                    gnt1;
    logic                    done0;
    logic                    done1;
    logic [BURST*DATA_W-1:0] word;
    logic                    busy;
    logic [ADDR_W-1:0]       rom_addr;
    logic [DATA_W-1:0]       rom_q;

    modport slave (
        input  req0, base0, req1, base1, rom_q,
        output gnt0, gnt1, done0, done1, word, busy, rom_addr
    );

    modport master (
        output req0, base0, req1, base1, rom_q,
        input  gnt0, gnt1, done0, done1, word, busy, rom_addr
    );
endinterface

// File: rtl/rom_fetch_arbiter.sv
// Round-robin arbiter and pipelined burst fetch engine for the shared
// nibble-wide password/ID ROM. Each grant streams BURST consecutive addresses
// and returns them packed MSB-first with a one-cycle done pulse.
module rom_fetch_arbiter #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 4,
    parameter int BURST   = 4,
    parameter int ROM_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    rom_fetch_arbiter_if.slave bus
);
    localparam int WORD_W = BURST * DATA_W;
    localparam int CNT_W  = $clog2(BURST + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic                gnt_q, gnt_d;
    logic                gnt_port_q, gnt_port_d;
    logic                last_served_q, last_served_d;
    logic                done_q, done_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [WORD_W-1:0]   word_sr_q, word_sr_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ROM_LAT:0]    vld_q, vld_d;

    logic issue;
    logic capture;
    logic pick;

    // State register: all flops, synchronous active-low reset abandons any burst.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!rst) begin
            state_q       <= IDLE;
            gnt_q         <= 1'b0;
            gnt_port_q    <= 1'b0;
            last_served_q <= 1'b1;
            done_q        <= 1'b0;
            word_q        <= '0;
            word_sr_q     <= '0;
            rom_addr_q    <= '0;
            cnt_q         <= '0;
            vld_q         <= '0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            gnt_port_q    <= gnt_port_d;
            last_served_q <= last_served_d;
            done_q        <= done_d;
            word_q        <= word_d;
            word_sr_q     <= word_sr_d;
            rom_addr_q    <= rom_addr_d;
            cnt_q         <= cnt_d;
            vld_q         <= vld_d;
        end
    end

    // Next-state: arbitration, address issue, capture pipeline and word assembly.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        gnt_d         = gnt_q;
        gnt_port_d    = gnt_port_q;
        last_served_d = last_served_q;
        done_d        = 1'b0;
        word_d        = word_q;
        word_sr_d     = word_sr_q;
        rom_addr_d    = rom_addr_q;
        cnt_d         = cnt_q;
        issue         = 1'b0;
        pick          = 1'b0;
        capture       = vld_q[ROM_LAT];

        // A valid bit leaving the pipeline means rom_q now holds that nibble.
        if (capture) begin
            word_sr_d = (word_sr_q << DATA_W) | WORD_W'(bus.rom_q);
        end

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // On a tie the port that was not served last wins.
                    pick       = (bus.req0 && bus.req1) ? ~last_served_q : bus.req1;
                    gnt_d      = 1'b1;
                    gnt_port_d = pick;
                    rom_addr_d = pick ? bus.base1 : bus.base0;
                    cnt_d      = CNT_W'(1);
                    word_sr_d  = '0;
                    issue      = 1'b1;
                    state_d    = (BURST == 1) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                rom_addr_d = rom_addr_q + ADDR_W'(1);
                cnt_d      = cnt_q + CNT_W'(1);
                issue      = 1'b1;
                if (cnt_q == CNT_W'(BURST - 1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Last nibble: exiting valid bit with nothing behind it.
                if (capture && (vld_q[ROM_LAT-1:0] == '0)) begin
                    word_d        = word_sr_d;
                    done_d        = 1'b1;
                    last_served_d = gnt_port_q;
                    state_d       = DONE;
                end
            end
            DONE: begin
                gnt_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        vld_d = {vld_q[ROM_LAT-1:0], issue};
    end

    // Outputs: steer the shared grant/done flops to the owning port.
    always_comb begin
        bus.gnt0     = gnt_q & ~gnt_port_q;
        bus.gnt1     = gnt_q & gnt_port_q;
        bus.done0    = done_q & ~gnt_port_q;
        bus.done1    = done_q & gnt_port_q;
        bus.word     = word_q;
        bus.busy     = (state_q != IDLE);
        bus.rom_addr = rom_addr_q;
    end
endmodule

// File: doc/rom_fetch_arbiter.md
Name: rom_fetch_arbiter

Overview:
- Shares the single synchronous nibble-wide password/ID ROM between two requesters: port 0 is the password controller, port 1 is the user-ID matcher or a future admin block.
- On a granted request, streams BURST consecutive addresses into the ROM in a pipelined fashion.
- Packs the returned nibbles MSB-first into one word and returns it with a one-cycle done pulse.
- Replaces per-client ROM sequencing (fetch / wait / wait / catch loops) with one arbitrated, pipelined fetch engine.

Parameters:
ADDR_W, 5, ROM address width
DATA_W, 4, ROM data width (one digit)
BURST, 4, nibbles fetched per request; word width = BURST*DATA_W
ROM_LAT, 2, ROM read latency in cycles

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-low reset
req0  in  1  fetch request, port 0; level, held until done0
base0  in  ADDR_W  start address, port 0
req1  in  1  fetch request, port 1; level, held until done1
base1  in  ADDR_W  start address, port 1
gnt0  out  1  port 0 owns the ROM (grant edge through done cycle)
gnt1  out  1  port 1 owns the ROM
done0  out  1  one-cycle pulse: word valid for port 0
done1  out  1  one-cycle pulse: word valid for port 1
word  out  BURST*DATA_W  assembled data; first nibble in MSBs; held until next done
busy  out  1  high whenever state != IDLE
rom_addr  out  ADDR_W  registered ROM address
rom_q  in  DATA_W  ROM data

Behaviour:
- Reset (rst=0 at an edge), all values take effect that edge:
  - state=IDLE; gnt0, gnt1, done0, done1, busy = 0.
  - word=0, rom_addr=0, last_served=1 (port 0 wins the first tie).
  - Capture pipeline valid bits cleared.
  - Applies in any state; an in-flight burst is abandoned, no done is generated, and no partial word is exposed.
- ROM contract: the value on rom_addr during cycle t appears on rom_q during cycle t+ROM_LAT.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE, arbitration at each edge:
  - Only one req high: grant it.
  - Both high: grant the port != last_served (round-robin).
  - None: stay in IDLE.
  - On grant (edge 0): set gnt, latch base into a private counter, rom_addr<=base, issue count=1, clear the word shift register, go to ISSUE.
- ISSUE: each edge, rom_addr<=rom_addr+1, modulo 2^ADDR_W (31 wraps to 0). After BURST addresses have been issued (edges 0..BURST-1), go to DRAIN; rom_addr holds its value.
- Capture:
  - Each issued address carries a valid bit through a (ROM_LAT+1)-deep shift pipeline.
  - At an edge where the valid bit exits, shift: word_sr <= {word_sr[top-DATA_W:0], rom_q}.
  - Nibble k (issued at edge k) is captured at edge k+ROM_LAT+1.
- DRAIN: wait until the last nibble is captured, at edge BURST+ROM_LAT (=6 with defaults). At that same edge:
  - word <= assembled value.
  - Pulse done of the granted port.
  - last_served <= granted port.
  - Go to DONE.
- DONE: lasts one cycle. At the next edge, gnt<=0, done<=0, go to IDLE.
  - Earliest next grant is the following edge.
  - Grant-to-grant spacing is BURST+ROM_LAT+2 = 8 edges.
- Request rules:
  - req changes while granted are ignored. A dropped req does not abort the burst; done still pulses.
  - base is sampled only at the grant edge.
  - A req still high after its done re-arbitrates normally; round-robin alternates if both stay high.
- gnt0 and gnt1 are never high simultaneously. done0 and done1 are never high simultaneously.

Test Plan:
- ROM model q=addr[3:0], ROM_LAT=2:
  - Reset, req0=1, base0=5 → gnt0 rises at edge 0.
  - rom_addr 5,6,7,8 on edges 0–3.
  - done0 pulses at edge 6 with word=0x5678; gnt0 low after edge 7.
- Wrap: req1, base1=30 → addresses 30,31,0,1; word=0xEF01 with done1.
- Tie after reset: req0=req1=1 continuously, base0=0, base1=8.
  - gnt0 first (0x0123).
  - gnt1 granted at edge 8 (0x89AB).
  - Then port 0 again; grants strictly alternate.
- Dropped request: req0 pulsed high for only 1 cycle → the full burst still runs; done0 pulses once; busy returns to 0 after DONE.
- Reset mid-burst: rst=0 at edge 3 of a grant → next cycle gnt/done/busy=0, word=0, rom_addr=0; no done pulse ever appears for that burst.
- Word hold: after a done, change rom_q and requests idle → word is unchanged until the next done.
